rc_filter_multichannel: RTL and testbench

RC_FILTER_MULTICHANNEL -- requirements
Module: rc_filter_multichannel

---
 rtl/rc_filter_multichannel.sv | 147 ++++++++++++++
 tb/tb_rc_filter_multichannel.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_filter_multichannel.sv
// rc_filter_multichannel
//   First-order RC filter (high-pass or low-pass) applied independently to
//   CHANNELS packed signed audio lanes. A single shared multiplier is
//   time-multiplexed: one channel per cycle during a sweep, and all lanes
//   commit together at the end of the sweep.
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-high
//   audio_clk_en : one-cycle sample strobe, accepted only in IDLE
//   in           : CHANNELS x DATA_WIDTH signed samples, lane k at [k*DW +: DW]
//   out          : filtered samples, same packing, held between commits
//   busy         : high while the sweep is in progress
//   overrun      : one-cycle pulse after a strobe that had to be dropped
module rc_filter_multichannel #(
  parameter int CLOCK_RATE   = 50000000,
  parameter int SAMPLE_RATE  = 48000,
  parameter int R            = 47000,
  parameter int C_35_SHIFTED = 1615,
  parameter int DATA_WIDTH   = 16,
  parameter int CHANNELS     = 2,
  parameter int MODE         = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           audio_clk_en,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in,
  output logic [CHANNELS*DATA_WIDTH-1:0] out,
  output logic                           busy,
  output logic                           overrun
);

  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH + 2;
  localparam int PW = DATA_WIDTH + 19;
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [63:0] DT    = (64'd1 << 32) / 64'(SAMPLE_RATE);
  localparam logic [63:0] RC    = (64'(R) * 64'(C_35_SHIFTED)) >> 3;
  localparam logic [63:0] ALPHA = (RC << 16) / (RC + DT);
  localparam logic [63:0] BETA  = (DT << 16) / (RC + DT);
  // Both coefficients are below 1.0 in Q16, so a positive 17-bit signed
  // value holds them and keeps the product at PW bits.
  localparam logic [63:0]        COEF64 = (MODE == 1) ? ALPHA : BETA;
  localparam logic signed [16:0] COEF   = COEF64[16:0];

  if (CLOCK_RATE / SAMPLE_RATE < CHANNELS + 2) begin : g_rate_check
    $fatal(1, "rc_filter_multichannel: too few clocks per sample for CHANNELS");
  end

  typedef enum logic [1:0] {IDLE, LATCH, CALC, COMMIT} state_t;

  state_t                state_q;
  logic [IW-1:0]         idx_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic signed [DW-1:0]  x_lat_q [CHANNELS];
  logic signed [DW-1:0]  x_prev_q[CHANNELS];
  logic signed [DW-1:0]  y_prev_q[CHANNELS];
  logic signed [DW-1:0]  res_q   [CHANNELS];
  logic signed [DW-1:0]  out_q   [CHANNELS];

  // Shared datapath, operating on the channel selected by idx_q.
  logic signed [DW-1:0]  x_sel, xp_sel, yp_sel;
  logic signed [SW-1:0]  x_e, xp_e, yp_e, sum_d;
  logic signed [PW-1:0]  sum_p, coef_p, yp_p, prod_d, shr_d, acc_d;
  logic signed [DW-1:0]  res_d;

  always_comb begin
    x_sel  = x_lat_q[idx_q];
    xp_sel = x_prev_q[idx_q];
    yp_sel = y_prev_q[idx_q];
    x_e    = {{2{x_sel[DW-1]}}, x_sel};
    xp_e   = {{2{xp_sel[DW-1]}}, xp_sel};
    yp_e   = {{2{yp_sel[DW-1]}}, yp_sel};
    if (MODE == 1) sum_d = yp_e + x_e - xp_e;
    else           sum_d = x_e - yp_e;
    sum_p  = {{(PW-SW){sum_d[SW-1]}}, sum_d};
    coef_p = {{(PW-17){1'b0}}, COEF};
    yp_p   = {{(PW-DW){yp_sel[DW-1]}}, yp_sel};
    prod_d = sum_p * coef_p;
    shr_d  = prod_d >>> 16;
    if (MODE == 1) acc_d = shr_d;
    else           acc_d = yp_p + shr_d;
    // In range iff every bit above the DW-bit sign bit matches it.
    if ((&acc_d[PW-1:DW-1]) || !(|acc_d[PW-1:DW-1])) res_d = acc_d[DW-1:0];
    else if (acc_d[PW-1])                               res_d = {1'b1, {(DW-1){1'b0}}};
    else                                                res_d = {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        x_lat_q[k]  <= '0;
        x_prev_q[k] <= '0;
        y_prev_q[k] <= '0;
        res_q[k]    <= '0;
        out_q[k]    <= '0;
      end
    end else begin
      overrun_q <= audio_clk_en && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (audio_clk_en) begin
            for (int unsigned k = 0; k < CHANNELS; k++)
              x_lat_q[k] <= in[k*DW +: DW];
            state_q <= LATCH;
          end
        end
        LATCH: begin
          idx_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= CALC;
        end
        CALC: begin
          res_q[idx_q] <= res_d;
          if (idx_q == IW'(CHANNELS - 1)) state_q <= COMMIT;
          else                            idx_q   <= idx_q + 1'b1;
        end
        COMMIT: begin
          for (int unsigned k = 0; k < CHANNELS; k++) begin
            out_q[k]    <= res_q[k];
            y_prev_q[k] <= res_q[k];
            x_prev_q[k] <= x_lat_q[k];
          end
          idx_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    out = '0;
    for (int unsigned k = 0; k < CHANNELS; k++)
      out[k*DW +: DW] = out_q[k];
  end

  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_rc_filter_multichannel.sv
// Bench for rc_filter_multichannel: three instances (HP 2ch, LP 2ch,
// HP 4ch) share clock and reset. A sample-level model predicts every
// output on every cycle; directed scenarios add literal expectations.
module tb_rc_filter_multichannel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  en = '0;
  logic [63:0] in_v [3];
  logic [63:0] dout [3];
  logic [2:0]  busy_w, ovr_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int nch(int i);
    return (i == 2) ? 4 : 2;
  endfunction

  function automatic int nmode(int i);
    return (i == 1) ? 0 : 1;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int CH = (k == 2) ? 4 : 2;
    localparam int MD = (k == 1) ? 0 : 1;
    logic [CH*16-1:0] din, dq;
    logic b, o;
    assign din = in_v[k][CH*16-1:0];
    rc_filter_multichannel #(.CHANNELS(CH), .MODE(MD)) u_dut (
      .clk(clk), .reset(rst), .audio_clk_en(en[k]),
      .in(din), .out(dq), .busy(b), .overrun(o)
    );
    assign dout[k]   = 64'(dq);
    assign busy_w[k] = b;
    assign ovr_w[k]  = o;
  end

  // Filter equations with hand-derived defaults: ALPHA=64923, BETA=612.
  function automatic int model_step(int mode, int x, int xp, int yp);
    longint v;
    if (mode == 1) v = (longint'(64923) * longint'(yp + x - xp)) >>> 16;
    else           v = longint'(yp) + ((longint'(612) * longint'(x - yp)) >>> 16);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return int'(v);
  endfunction

  // Sample-level model: an accepted strobe commits CH+2 edges later;
  // strobes arriving before that commit are dropped.
  int   lx [3][4];
  int   mx [3][4];
  int   my [3][4];
  int   eo [3][4];
  int   cnt [3];
  logic eovr [3];
  logic ebusy [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 4; j++) begin
          lx[i][j] <= 0; mx[i][j] <= 0; my[i][j] <= 0; eo[i][j] <= 0;
        end
        cnt[i] <= 0; eovr[i] <= 1'b0; ebusy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        eovr[i]  <= en[i] && (cnt[i] != 0);
        ebusy[i] <= (cnt[i] >= 2);
        if (cnt[i] != 0) begin
          cnt[i] <= cnt[i] - 1;
          if (cnt[i] == 1) begin
            for (int j = 0; j < nch(i); j++) begin
              my[i][j] <= model_step(nmode(i), lx[i][j], mx[i][j], my[i][j]);
              eo[i][j] <= model_step(nmode(i), lx[i][j], mx[i][j], my[i][j]);
              mx[i][j] <= lx[i][j];
            end
          end
        end else if (en[i]) begin
          for (int j = 0; j < nch(i); j++)
            lx[i][j] <= int'($signed(in_v[i][j*16 +: 16]));
          cnt[i] <= nch(i) + 2;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane(int i, int j);
    return int'($signed(dout[i][j*16 +: 16]));
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("inst%0d busy", i), int'(busy_w[i]), int'(ebusy[i]));
      chk($sformatf("inst%0d overrun", i), int'(ovr_w[i]), int'(eovr[i]));
      for (int j = 0; j < nch(i); j++)
        chk($sformatf("inst%0d out ch%0d", i, j), lane(i, j), eo[i][j]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the strobe is sampled by the next rising edge.
  task automatic pulse(input int i, input logic [63:0] v);
    in_v[i] = v;
    en[i]   = 1'b1;
    @(negedge clk);
    en[i]   = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  function automatic logic [63:0] pack4(int a, int b, int c, int d);
    logic [63:0] v;
    v[15:0]  = 16'(a);
    v[31:16] = 16'(b);
    v[47:32] = 16'(c);
    v[63:48] = 16'(d);
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, cur, ovr_cnt;
    for (int i = 0; i < 3; i++) in_v[i] = '0;
    rst = 1'b1;
    cyc(3);
    for (int i = 0; i < 3; i++) begin
      chk("reset out", int'(dout[i] != 0), 0);
      chk("reset busy", int'(busy_w[i]), 0);
      chk("reset overrun", int'(ovr_w[i]), 0);
    end
    rst = 1'b0;
    cyc(1);

    // HP step on inst0 and LP step on inst1, launched together.
    in_v[0] = pack4(1000, 0, 0, 0);
    in_v[1] = pack4(1000, 0, 0, 0);
    en[1:0] = 2'b11;
    @(negedge clk);
    en = '0;
    cyc(3);
    chk("hp latency hold", lane(0, 0), 0);
    cyc(1);
    chk("hp step 1", lane(0, 0), 990);
    chk("hp ch1 idle", lane(0, 1), 0);
    chk("lp step 1", lane(1, 0), 9);
    // Strobe in the cycle right after COMMIT.
    in_v[0] = pack4(1000, 0, 0, 0);
    en[1:0] = 2'b11;
    @(negedge clk);
    en = '0;
    cyc(4);
    chk("hp step 2", lane(0, 0), 980);
    chk("hp ch1 idle 2", lane(0, 1), 0);
    chk("lp step 2", lane(1, 0), 18);

    // LP approaches the step monotonically without overshoot.
    prev = lane(1, 0);
    for (int n = 0; n < 40; n++) begin
      pulse(1, pack4(1000, 0, 0, 0));
      cyc(4);
      cur = lane(1, 0);
      chk("lp monotone", int'(cur >= prev), 1);
      chk("lp bounded", int'(cur <= 1000), 1);
      prev = cur;
    end

    // Saturation: large positive history, then full negative swing.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      pulse(0, pack4(32767, 0, 0, 0));
      cyc(4);
    end
    pulse(0, pack4(-32768, 0, 0, 0));
    cyc(4);
    chk("hp saturate low", lane(0, 0), -32768);

    // Overrun: second strobe two cycles after the first is dropped.
    do_reset();
    in_v[0] = pack4(1000, 0, 0, 0);
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    ovr_cnt = 0;
    @(negedge clk);
    in_v[0] = pack4(5000, 0, 0, 0);
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (ovr_w[0]) ovr_cnt++;
      @(negedge clk);
    end
    chk("overrun pulse count", ovr_cnt, 1);
    chk("overrun single result", lane(0, 0), 990);

    // Reset mid-sweep clears output and history.
    pulse(0, pack4(1000, 0, 0, 0));
    cyc(2);
    rst = 1'b1;
    #1;
    chk("mid reset out", lane(0, 0), 0);
    chk("mid reset busy", int'(busy_w[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1);
    pulse(0, pack4(1000, 0, 0, 0));
    cyc(4);
    chk("post reset step", lane(0, 0), 990);

    // Four-channel instance: latency 6, all lanes in one commit.
    do_reset();
    pulse(2, pack4(100, 200, -300, 0));
    cyc(5);
    chk("ch4 latency hold", int'(dout[2] != 0), 0);
    cyc(1);
    chk("ch4 lane0", lane(2, 0), 99);
    chk("ch4 lane1", lane(2, 1), 198);
    chk("ch4 lane2", lane(2, 2), -298);
    chk("ch4 lane3", lane(2, 3), 0);

    cyc(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
